// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and the controller states.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane datapath: pulls a byte/half out of a memory word with extension, and
// merges store data into a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    ext_o    = word_i;
    merged_o = wdata_i;
    case (size_i)
      SZ_B: begin
        ext_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
        merged_o = word_i;
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        ext_o = {{16{~uns_i & half_sel[15]}}, half_sel};
        merged_o = word_i;
        merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ext_o    = word_i;
        merged_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: one request at a time, sub-word stores done as read-modify-write
// against a word-only data memory.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              write_q, uns_q, err_q;
  logic [1:0]        size_q, lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       req_wdata_q;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       ext, merged;
  logic              accept, req_err;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Holding ready low during reset keeps a request from being "accepted" and dropped.
  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign req_err   = (req_size == 2'b11)
                   | ((req_size == SZ_H) & req_addr[0])
                   | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));

  lsu_align u_align (
    .word_i   (mem_rdata),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .wdata_i  (req_wdata_q),
    .ext_o    (ext),
    .merged_o (merged)
  );

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        rdata_d = '0;
        if (req_err)                            state_d = RESP;
        else if (req_write && req_size == SZ_W) begin
          state_d = WR;
          wdata_d = req_wdata;
        end else                                state_d = RD;
      end
      RD: begin
        if (write_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rdata_d = ext;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      addr_q      <= '0;
      req_wdata_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      if (accept) begin
        write_q     <= req_write;
        uns_q       <= req_unsigned;
        err_q       <= req_err;
        size_q      <= req_size;
        lane_q      <= req_addr[1:0];
        addr_q      <= req_addr[ADDR_W+1:2];
        req_wdata_q <= req_wdata;
      end
    end
  end

  assign mem_addr   = addr_q;
  assign mem_write  = (state_q == WR) & ~rst;
  assign mem_wdata  = wdata_q;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) & err_q;
  assign resp_rdata = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: word memory, a mask/shift reference model with timed expectation
// queues, a per-cycle compare process, and directed vectors with literal results.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_write;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  lsu_rmw #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  typedef struct { int cyc; logic [9:0] idx; logic [31:0] data; logic [31:0] old; } wr_t;
  typedef struct { int cyc; logic err; logic [31:0] rdata; } rsp_t;
  wr_t  wq[$];
  rsp_t rq[$];

  int checks = 0, failures = 0;
  int cyc = 0, acc_cnt = 0, rsp_cnt = 0;
  int last_acc_cyc = 0, last_wr_cyc = 0, last_rsp_cyc = 0;
  logic [9:0]  last_wr_addr = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0, prev_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h cyc=%0d", n, act, exp, cyc);
    end
  endtask

  // Reference: what the accepted request must produce, from lane masks and shifts.
  task automatic model_accept(input int t);
    logic [31:0] a, w, v, mask, nw;
    logic [9:0]  idx;
    int          sh;
    logic        err;
    a   = req_addr;
    idx = a[11:2];
    err = (req_size == 2'b11) || (req_size == 2'b01 && a[0]) ||
          (req_size == 2'b10 && a[1:0] != 2'b00);
    w   = ref_mem[idx];
    sh  = (req_size == 2'b01) ? 16 * a[1] : 8 * a[1:0];
    mask = ((req_size == 2'b01) ? 32'hFFFF : 32'hFF) << sh;
    if (err) begin
      rq.push_back('{t + 1, 1'b1, 32'h0});
    end else if (!req_write) begin
      v = (req_size == 2'b10) ? w : (w & mask) >> sh;
      if (!req_unsigned && req_size == 2'b00 && v[7])  v = v | 32'hFFFFFF00;
      if (!req_unsigned && req_size == 2'b01 && v[15]) v = v | 32'hFFFF0000;
      rq.push_back('{t + 2, 1'b0, v});
    end else if (req_size == 2'b10) begin
      wq.push_back('{t + 1, idx, req_wdata, w});
      ref_mem[idx] = req_wdata;
      rq.push_back('{t + 2, 1'b0, 32'h0});
    end else begin
      nw = (w & ~mask) | ((req_wdata << sh) & mask);
      wq.push_back('{t + 2, idx, nw, w});
      ref_mem[idx] = nw;
      rq.push_back('{t + 3, 1'b0, 32'h0});
    end
  endtask

  always @(negedge clk) begin
    wr_t  we;
    rsp_t re;
    if (rst) begin
      chk("rst_no_write", {31'b0, mem_write}, 32'd0);
      while (wq.size() != 0) begin
        ref_mem[wq[$].idx] = wq[$].old;
        void'(wq.pop_back());
      end
      rq.delete();
      rsp_cnt  = acc_cnt;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) chk("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      prev_rst = 1'b0;
      chk("ready_vs_outstanding", {31'b0, req_ready}, {31'b0, acc_cnt == rsp_cnt});
      if (mem_write) begin
        if (wq.size() == 0) chk("unexpected_write", {22'b0, mem_addr}, 32'hFFFFFFFF);
        else begin
          we = wq.pop_front();
          chk("wr_cycle", cyc, we.cyc);
          chk("wr_addr", {22'b0, mem_addr}, {22'b0, we.idx});
          chk("wr_data", mem_wdata, we.data);
          last_wr_cyc = cyc; last_wr_addr = mem_addr;
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        chk("missing_write", 32'd0, wq[0].data);
        void'(wq.pop_front());
      end
      if (resp_valid) begin
        if (rq.size() == 0) chk("unexpected_resp", resp_rdata, 32'hFFFFFFFF);
        else begin
          re = rq.pop_front();
          chk("rsp_cycle", cyc, re.cyc);
          chk("rsp_err", {31'b0, resp_err}, {31'b0, re.err});
          chk("rsp_rdata", resp_rdata, re.rdata);
        end
        rsp_cnt++;
        last_rsp_cyc = cyc; last_rdata = resp_rdata; last_err = resp_err;
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
        chk("missing_resp", 32'd0, 32'd1);
        void'(rq.pop_front());
        rsp_cnt++;
      end
      if (req_valid && req_ready) begin
        model_accept(cyc);
        acc_cnt++;
        last_acc_cyc = cyc;
      end
    end
  end

  task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
  endtask

  task automatic wait_acc();
    int n = acc_cnt;
    int k = 0;
    while (acc_cnt == n && k < 40) begin @(posedge clk); k++; end
    if (acc_cnt == n) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (rsp_cnt != acc_cnt && k < 40) begin @(negedge clk); #1; k++; end
    if (rsp_cnt != acc_cnt) chk("resp_timeout", rsp_cnt, acc_cnt);
  endtask

  task automatic req(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    set_req(w, sz, u, a, d);
    wait_acc();
    #1 req_valid = 1'b0;
    wait_done();
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    mem[idx] = v; ref_mem[idx] = v;
  endtask

  initial begin
    int n0, r0, bad;
    for (int i = 0; i < 1024; i++) poke(i, 32'h9E3779B9 * i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_err", {31'b0, resp_err}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd1);

    // sw / lw
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_wr_lat", last_wr_cyc - last_acc_cyc, 32'd1);
    chk("sw_wr_idx", {22'b0, last_wr_addr}, 32'd4);
    chk("sw_rsp_lat", last_rsp_cyc - last_acc_cyc, 32'd2);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_data", last_rdata, 32'hDEADBEEF);
    chk("lw_lat", last_rsp_cyc - last_acc_cyc, 32'd2);

    // byte RMW
    poke(4, 32'h11223344);
    req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAB);
    chk("sb_wr_lat", last_wr_cyc - last_acc_cyc, 32'd2);
    chk("sb_rsp_lat", last_rsp_cyc - last_acc_cyc, 32'd3);
    chk("sb_mem", mem[4], 32'h11AB3344);

    // sub-word loads
    poke(8, 32'h8000FF7F);
    req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0); chk("lb_20", last_rdata, 32'h0000007F);
    req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0); chk("lb_21", last_rdata, 32'hFFFFFFFF);
    req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0); chk("lbu_21", last_rdata, 32'h000000FF);
    req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0); chk("lh_22", last_rdata, 32'hFFFF8000);
    req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0); chk("lhu_22", last_rdata, 32'h00008000);
    req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0); chk("lbu_23", last_rdata, 32'h00000080);

    // errors (address bits above the index are ignored elsewhere; here only alignment matters)
    req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    chk("lw_mis_err", {31'b0, last_err}, 32'd1);
    chk("lw_mis_data", last_rdata, 32'd0);
    chk("lw_mis_lat", last_rsp_cyc - last_acc_cyc, 32'd1);
    req(1'b1, 2'b01, 1'b0, 32'h11, 32'h5555);
    chk("sh_mis_err", {31'b0, last_err}, 32'd1);
    req(1'b1, 2'b11, 1'b0, 32'h30, 32'h77);
    chk("sz11_err", {31'b0, last_err}, 32'd1);
    chk("sz11_lat", last_rsp_cyc - last_acc_cyc, 32'd1);

    // half store, high address bits ignored
    req(1'b1, 2'b01, 1'b0, 32'hFFFF_F022, 32'hABCD1234);
    chk("sh_mem", mem[8], 32'h1234FF7F);

    // reset during RD of a sub-word store
    @(posedge clk); #1;
    set_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h55);
    wait_acc();
    #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
    req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rmw_rst_old", last_rdata, 32'h1234FF7F);

    // back-to-back with req_valid held high
    n0 = acc_cnt; r0 = rsp_cnt;
    @(posedge clk); #1;
    set_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);        wait_acc();
    #1 set_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h66);    wait_acc();
    #1 set_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);     wait_acc();
    #1 set_req(1'b1, 2'b10, 1'b0, 32'h18, 32'hC0FFEE00); wait_acc();
    #1 req_valid = 1'b0;
    wait_done();
    chk("hs_accepts", acc_cnt - n0, 32'd4);
    chk("hs_resps", rsp_cnt - r0, 32'd4);
    chk("hs_sw_mem", mem[6], 32'hC0FFEE00);

    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("wq_empty", wq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
